// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver feeding a first-word-fall-through FIFO.
// Define UART_RX_GLITCH_FILTER_EN to decide each bit by a 3-sample majority vote.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        en,
    input  logic [DIV_W-1:0]            clk_div,
    input  logic [3:0]                  cfg_bits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic                        rx,
    input  logic                        rd_en,
    output logic [DATA_BITS-1:0]        rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        err_clr,
    output logic                        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_next;
    logic                 rx_s1, rx_s2, rx_d;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [3:0]           s;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg, shreg_ins;
    logic                 perr, ferr, stop_second;
    logic                 bit_val, samp;
    logic                 parity_on, exp_par;
    logic                 push_req, frame_set;

    assign tick = en && (state != IDLE) && (div_cnt == clk_div);

`ifdef UART_RX_GLITCH_FILTER_EN
    localparam logic [3:0] SAMP_S = 4'd8;
    logic v6, v7;
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            v6 <= 1'b1;
            v7 <= 1'b1;
        end else if (tick && s == 4'd6) begin
            v6 <= rx_s2;
        end else if (tick && s == 4'd7) begin
            v7 <= rx_s2;
        end
    end
    assign bit_val = (v6 & v7) | (v6 & rx_s2) | (v7 & rx_s2);
`else
    localparam logic [3:0] SAMP_S = 4'd7;
    assign bit_val = rx_s2;
`endif

    assign samp      = tick && (s == SAMP_S);
    assign parity_on = (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
    // odd mode expects the inverse of the data XOR
    assign exp_par   = (^shreg) ^ (cfg_parity == 2'd1);
    assign busy      = (state != IDLE);

    always_comb begin
        shreg_ins = shreg;
        for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt == 4'(i)) shreg_ins[i] = bit_val;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        case (state)
            IDLE: begin
                if (en && rx_d && !rx_s2) state_next = START;
            end
            START: begin
                if (samp && bit_val)             state_next = IDLE;
                else if (tick && s == 4'd15)     state_next = DATA;
            end
            DATA: begin
                if (tick && s == 4'd15 && bit_cnt == cfg_bits - 4'd1)
                    state_next = parity_on ? PARITY : STOP;
            end
            PARITY: begin
                if (tick && s == 4'd15) state_next = STOP;
            end
            STOP: begin
                if (samp && (stop_second || !cfg_stop2)) begin
                    state_next = IDLE;
                    if (ferr || !bit_val) frame_set = 1'b1;
                    else                  push_req  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!en) begin
            state_next = IDLE;
            push_req   = 1'b0;
            frame_set  = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_d        <= 1'b1;
            div_cnt     <= '0;
            s           <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            perr        <= 1'b0;
            ferr        <= 1'b0;
            stop_second <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            if (!en || state == IDLE || div_cnt == clk_div) div_cnt <= '0;
            else                                            div_cnt <= div_cnt + DIV_W'(1);
            if (state == IDLE) begin
                s           <= '0;
                bit_cnt     <= '0;
                shreg       <= '0;
                perr        <= 1'b0;
                ferr        <= 1'b0;
                stop_second <= 1'b0;
            end else begin
                if (tick) s <= s + 4'd1;
                if (state == DATA && samp) shreg <= shreg_ins;
                if (state == DATA && tick && s == 4'd15) bit_cnt <= bit_cnt + 4'd1;
                if (state == PARITY && samp && bit_val != exp_par) perr <= 1'b1;
                if (state == STOP && samp && !bit_val) ferr <= 1'b1;
                if (state == STOP && tick && s == 4'd15) stop_second <= 1'b1;
            end
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic                 full, pop, push;

    assign full = (level == LW'(FIFO_DEPTH));
    assign pop  = rd_en && (level != '0);
    // a pop in the same cycle frees the slot the push needs
    assign push = push_req && (!full || pop);

    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (!push && pop) level <= level - LW'(1);
        end
    end

    assign rd_valid   = (level != '0);
    assign fifo_level = level;
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= (parity_err & ~err_clr) | (push_req & perr);
            frame_err  <= (frame_err & ~err_clr) | frame_set;
            overrun    <= (overrun & ~err_clr) | (push_req & full & ~pop);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed serial frames checked against a queue-level receiver model.
// Add +define+UART_RX_GLITCH_FILTER_EN to also exercise the majority-vote filter.
module tb_uart_rx_fifo;
    localparam int DEPTH   = 16;
    localparam int CLK_DIV = 4;
    localparam int BIT_CYC = 16 * (CLK_DIV + 1);
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int SAMP_TICKS = 9;
    localparam int FIRST_LAT  = 768;
`else
    localparam int SAMP_TICKS = 8;
    localparam int FIRST_LAT  = 763;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET, en, cfg_stop2, rx, rd_en, err_clr;
    logic [15:0] clk_div;
    logic [3:0]  cfg_bits;
    logic [1:0]  cfg_parity;
    logic [7:0]  rd_data;
    logic        rd_valid, parity_err, frame_err, overrun, busy;
    logic [4:0]  fifo_level;

    uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .en(en), .clk_div(clk_div),
        .cfg_bits(cfg_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .rx(rx), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_level(fifo_level), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .err_clr(err_clr), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        longint   t;
        bit       ferr;
        bit       perr;
        logic [8:0] word;
    } ev_t;

    longint     cyc = 0;
    ev_t        evq[$];
    logic [8:0] mq[$];
    bit         m_perr = 0, m_ferr = 0, m_ovr = 0;

    // Model: a frame's outcome lands on the posedge ending its final stop sample.
    always @(posedge HCLK) begin
        bit push, pset, fset, oset, do_pop, was_full;
        ev_t e;
        cyc++;
        if (HRESET) begin
            mq.delete();
            evq.delete();
            m_perr = 0; m_ferr = 0; m_ovr = 0;
        end else begin
            push = 0; pset = 0; fset = 0; oset = 0;
            if (evq.size() > 0 && evq[0].t == cyc) begin
                e = evq.pop_front();
                if (e.ferr) fset = 1;
                else begin push = 1; pset = e.perr; end
            end
            was_full = (mq.size() == DEPTH);
            do_pop = rd_en && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (push) begin
                if (!was_full || do_pop) mq.push_back(e.word);
                else oset = 1;
            end
            m_perr = (m_perr && !err_clr) || pset;
            m_ferr = (m_ferr && !err_clr) || fset;
            m_ovr  = (m_ovr  && !err_clr) || oset;
        end
    end

    longint rise_cyc = 0;
    bit     prev_valid = 0;

    always @(negedge HCLK) begin
        chk("rd_valid",   32'(rd_valid),   32'(mq.size() != 0));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("rd_data",    32'(rd_data),    mq.size() != 0 ? 32'(mq[0]) : 32'd0);
        chk("parity_err", 32'(parity_err), 32'(m_perr));
        chk("frame_err",  32'(frame_err),  32'(m_ferr));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        if (rd_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rd_valid;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge HCLK);
            #1 rx = 1'b1;
        end
    endtask

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge HCLK);
            #1 rx = v;
        end
    endtask

    // Builds and drives one frame; returns the cycle the start bit was driven.
    task automatic send_frame(input logic [8:0] data, input bit par_flip,
                              input bit stop1, input bit stop2v,
                              input int blip_bit, output longint c0);
        logic [15:0] fb;
        logic [8:0]  word;
        int          n;
        bit          par_on;
        ev_t         e;
        word = data & 9'((1 << cfg_bits) - 1);
        par_on = (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
        fb = '0;
        n = 1;
        for (int i = 0; i < int'(cfg_bits); i++) begin
            fb[n] = word[i];
            n++;
        end
        if (par_on) begin
            fb[n] = (^word) ^ (cfg_parity == 2'd1) ^ par_flip;
            n++;
        end
        fb[n] = stop1;
        n++;
        if (cfg_stop2) begin
            fb[n] = stop2v;
            n++;
        end
        e.word = word;
        e.perr = par_on && par_flip;
        e.ferr = !stop1 || (cfg_stop2 && !stop2v);
        c0 = 0;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < BIT_CYC; k++) begin
                @(negedge HCLK);
                #1;
                if (b == 0 && k == 0) begin
                    c0 = cyc;
                    e.t = cyc + 3 + (CLK_DIV + 1) * (16 * (n - 1) + SAMP_TICKS);
                    evq.push_back(e);
                end
                rx = (b == blip_bit && k >= 38 && k <= 42) ? 1'b0 : fb[b];
            end
        end
    endtask

    task automatic pop_expect(input string name, input logic [7:0] v);
        @(negedge HCLK);
        chk(name, 32'(rd_data), 32'(v));
        #1 rd_en = 1'b1;
        @(negedge HCLK);
        #1 rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        @(negedge HCLK);
        #1 err_clr = 1'b1;
        @(negedge HCLK);
        #1 err_clr = 1'b0;
    endtask

    initial begin
        longint c0;
        HRESET = 1'b1; en = 1'b1; clk_div = 16'(CLK_DIV);
        cfg_bits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("reset_valid", 32'(rd_valid), 0);
        chk("reset_level", 32'(fifo_level), 0);
        chk("reset_data",  32'(rd_data), 0);
        chk("reset_busy",  32'(busy), 0);
        chk("reset_flags", {29'd0, parity_err, frame_err, overrun}, 0);
        #1 HRESET = 1'b0;
        idle(10);

        send_frame(9'h55, 0, 1, 1, -1, c0);
        idle(20);
        chk("lat_55",   32'(rise_cyc - c0), FIRST_LAT);
        chk("data_55",  32'(rd_data), 32'h55);
        chk("level_55", 32'(fifo_level), 1);
        chk("flags_55", {29'd0, parity_err, frame_err, overrun}, 0);
        pop_expect("pop_55", 8'h55);

        cfg_parity = 2'd2;
        send_frame(9'h0A3, 1, 1, 1, -1, c0);
        idle(20);
        chk("perr_a3", 32'(parity_err), 1);
        chk("data_a3", 32'(rd_data), 32'hA3);
        pop_expect("pop_a3", 8'hA3);
        clear_flags();
        chk("perr_clr", 32'(parity_err), 0);
        cfg_parity = 2'd0;

        send_frame(9'h3C, 0, 0, 1, -1, c0);
        idle(20);
        chk("ferr_3c",  32'(frame_err), 1);
        chk("level_3c", 32'(fifo_level), 0);
        send_frame(9'h3C, 0, 1, 1, -1, c0);
        idle(20);
        chk("data_3c", 32'(rd_data), 32'h3C);
        pop_expect("pop_3c", 8'h3C);
        clear_flags();

        for (int i = 0; i <= 16; i++) send_frame(9'(i), 0, 1, 1, -1, c0);
        idle(20);
        chk("ovr_level", 32'(fifo_level), 16);
        chk("ovr_flag",  32'(overrun), 1);
        for (int i = 0; i < 16; i++) pop_expect("ovr_pop", 8'(i));
        @(negedge HCLK);
        chk("ovr_empty", 32'(rd_valid), 0);
        clear_flags();

        cfg_bits = 4'd5; cfg_stop2 = 1'b1;
        send_frame(9'h1F, 0, 1, 1, -1, c0);
        send_frame(9'h0A, 0, 1, 1, -1, c0);
        idle(20);
        chk("s2_level", 32'(fifo_level), 2);
        pop_expect("s2_pop0", 8'h1F);
        pop_expect("s2_pop1", 8'h0A);
        send_frame(9'h0A, 0, 1, 0, -1, c0);
        idle(20);
        chk("s2_ferr",  32'(frame_err), 1);
        chk("s2_empty", 32'(fifo_level), 0);
        cfg_bits = 4'd8; cfg_stop2 = 1'b0;

        drive(0, 20);
        chk("pulse_busy", 32'(busy), 1);
        idle(100);
        chk("pulse_idle",  32'(busy), 0);
        chk("pulse_level", 32'(fifo_level), 0);

`ifdef UART_RX_GLITCH_FILTER_EN
        send_frame(9'h0FF, 0, 1, 1, 4, c0);
        idle(20);
        chk("glitch_ff", 32'(rd_data), 32'hFF);
        pop_expect("glitch_pop", 8'hFF);
`endif

        send_frame(9'h81, 0, 1, 1, -1, c0);
        idle(20);
        chk("pre_rst_level", 32'(fifo_level), 1);
        drive(0, BIT_CYC);
        drive(1, 40);
        chk("pre_rst_busy", 32'(busy), 1);
        @(negedge HCLK);
        #1 HRESET = 1'b1; rx = 1'b1;
        #2;
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_data",  32'(rd_data), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_flags", {29'd0, parity_err, frame_err, overrun}, 0);
        repeat (2) @(negedge HCLK);
        #1 HRESET = 1'b0;
        idle(10);
        send_frame(9'h5A, 0, 1, 1, -1, c0);
        idle(20);
        chk("post_rst_data",  32'(rd_data), 32'h5A);
        chk("post_rst_level", 32'(fifo_level), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable, parametrised UART receiver with 16x oversampling, configurable frame format and a first-word-fall-through (FWFT) receive FIFO.
- Successor to the bench serial terminal. It replaces the fixed-bit-time, 8N1-only, unbuffered behavioural model.
- Used in two places:
  - in-SoC, as an RX channel behind the APB UART;
  - in benches, as a cycle-accurate monitor on RsTx lines.

Parameters:
- DATA_BITS, 8, maximum frame data width (5..9).
- FIFO_DEPTH, 16, RX FIFO entries; power of two, >=2.
- DIV_W, 16, width of the baud prescaler.

Ports:
- HCLK  input  1  system clock.
- HRESET  input  1  asynchronous, active-high reset.
- en  input  1  receiver enable.
- clk_div  input  DIV_W  HCLK cycles per oversample tick, minus 1.
- cfg_bits  input  4  data bits per frame (5..DATA_BITS).
- cfg_parity  input  2  parity mode: 0 none, 1 odd, 2 even, 3 none.
- cfg_stop2  input  1  1 = two stop bits checked.
- rx  input  1  serial input, asynchronous to HCLK.
- rd_en  input  1  pop the FIFO head.
- rd_data  output  DATA_BITS  FIFO head, zero-extended above cfg_bits.
- rd_valid  output  1  FIFO not empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of entries.
- parity_err  output  1  sticky flag.
- frame_err  output  1  sticky flag.
- overrun  output  1  sticky flag.
- err_clr  input  1  clears all sticky flags.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - rx synchroniser flops = 1; FSM = IDLE;
  - rd_data = 0, rd_valid = 0, fifo_level = 0;
  - all flags = 0; busy = 0.
- Input path: rx passes a 2-flop synchroniser; all decisions use the synchronised rx.
- Prescaler:
  - counts 0..clk_div and emits a 1-cycle tick at clk_div;
  - held at 0 while en=0 or FSM=IDLE, so the first tick falls clk_div+1 cycles after the start edge;
  - one bit = 16 ticks.
- Oversample counter s (4-bit): cleared on every state entry; increments per tick; bit sample taken at s=7.
- IDLE:
  - synchronised 1->0 transition while en=1 -> START.
- START:
  - at s=7: rx=1 -> IDLE (false start, nothing pushed, no flag);
  - otherwise at s=15 -> DATA.
- DATA:
  - samples cfg_bits bits LSB first; each bit occupies s=0..15;
  - after the last bit -> PARITY if cfg_parity is 1 or 2, else STOP.
- PARITY:
  - sample at s=7 and compare with computed parity; a mismatch sets the internal perr bit;
  - at s=15 -> STOP.
- STOP:
  - sample at s=7; rx=0 sets the internal ferr bit.
  - If cfg_stop2=1, the first stop runs to s=15 and a second stop is sampled at s=7.
  - At the final stop sample:
    - ferr=1 -> frame_err=1 and the word is discarded;
    - otherwise the word is pushed, and parity_err|=perr.
  - -> IDLE in the same cycle, so a back-to-back start edge half a bit later is caught.
- Latency: rd_valid rises 1 HCLK after the final stop sample cycle.
- en deasserted mid-frame: FSM -> IDLE next cycle; partial word dropped; FIFO and flags kept.
- cfg_*/clk_div: changed only while busy=0; changes while busy=1 give an undefined frame only.
- FIFO:
  - FWFT: rd_data is always the head entry.
  - rd_en with rd_valid=0 is ignored.
  - Push while full: word dropped, overrun=1, contents unchanged.
  - Push and pop in the same cycle while full: both occur, level stays FIFO_DEPTH, no overrun.
  - Push and pop in the same cycle while empty: the word is written; the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Flags: err_clr clears all sticky flags; if a set and err_clr coincide, the set wins.
- HRESET mid-frame: everything returns to reset values immediately; the FIFO is emptied.

Optional Feature:
- Macro UART_RX_GLITCH_FILTER_EN.
- Defined:
  - each bit decision is a majority vote of the samples at s=6,7,8, evaluated at s=8;
  - the start edge must also be confirmed low by this majority, else -> IDLE;
  - rejects pulses shorter than 2 ticks.
- Undefined: a single sample at s=7 is used, exactly as described above.

Test Plan:
- Setup for all: clk_div=4, so a bit is 80 HCLK cycles.
- 8N1 0x55 on rx -> rd_data=0x55, rd_valid=1 exactly 1 cycle after the stop sample, fifo_level=1, no flags set.
- cfg_parity=2, cfg_bits=8, 0xA3 sent with parity bit 1 (wrong) -> word 0xA3 pushed, parity_err=1; err_clr pulse -> parity_err=0.
- 8N1 0x3C with stop bit driven 0 -> frame_err=1, fifo_level=0; then 0x3C with correct framing -> rd_data=0x3C.
- 17 back-to-back 8N1 bytes 0x00..0x10 with no reads -> fifo_level=16, overrun=1; 16 pops return 0x00..0x0F in order, and rd_valid=0 after the last pop.
- cfg_bits=5, cfg_stop2=1, 0x1F then 0x0A -> reads 0x1F, 0x0A; stop2 low in the second frame -> frame_err=1.
- Low pulse of 20 HCLK on idle rx -> IDLE, no push. With UART_RX_GLITCH_FILTER_EN defined, a 1-tick low blip mid-data-bit does not alter the received 0xFF. HRESET mid-frame -> all outputs return to reset values.
